// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the hazard controller and CONTROL:
// FSM state encodings, default widths and the control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 4;

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_RUN    = 4'b1100;
    localparam hz_ctl_t CTL_STALL  = 4'b0001;
    localparam hz_ctl_t CTL_HALT   = 4'b0110;
    localparam hz_ctl_t CTL_BRANCH = 4'b1110;
    localparam hz_ctl_t CTL_DRAIN  = 4'b0011;
    localparam hz_ctl_t CTL_FROZEN = 4'b0001;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_wb_en;
    logic              branch_taken;
    logic              halt_dec;
    logic              resume;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic              halted;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rd, ex_mem_read, ex_wb_en,
        output branch_taken, halt_dec, resume,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
        input  halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rd, ex_mem_read, ex_wb_en,
        input  branch_taken, halt_dec, resume,
        output pc_write, ifid_write, ifid_flush, idex_flush,
        output halted, state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and async active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and HALT drain sequencing
// for the 5-stage pipeline, plus stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  CLOCK,
    input  logic                  CLEAR,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          hz, hit_rs, hit_rt;
    logic          stall_en, flush_en;
    hz_ctl_t       ctl;

    assign hit_rs = bus.id_use_rs && (bus.ex_rd == bus.id_rs);
    assign hit_rt = bus.id_use_rt && (bus.ex_rd == bus.id_rt);
    assign hz     = bus.ex_mem_read && bus.ex_wb_en && (hit_rs || hit_rt);

    // Gating RUN decisions with CLEAR keeps outputs at RUN defaults in reset.
    always_comb begin
        state_d  = state_q;
        drn_d    = drn_q;
        ctl      = CTL_RUN;
        stall_en = 1'b0;
        flush_en = 1'b0;
        unique case (1'b1)
            (state_q == ST_DRAIN): begin
                ctl = CTL_DRAIN;
                if (drn_q == '0) state_d = ST_HALTED;
                else             drn_d   = drn_q - 1'b1;
            end
            (state_q == ST_HALTED): begin
                ctl = CTL_FROZEN;
                if (bus.resume) state_d = ST_RUN;
            end
            default: begin
                if (CLEAR) begin
                    if (hz) begin
                        ctl      = CTL_STALL;
                        stall_en = 1'b1;
                    end else if (bus.halt_dec) begin
                        ctl     = CTL_HALT;
                        drn_d   = DRAIN_LD;
                        state_d = ST_DRAIN;
                    end else if (bus.branch_taken) begin
                        ctl      = CTL_BRANCH;
                        flush_en = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge CLEAR) begin
        if (!CLEAR) begin
            state_q <= ST_RUN;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLOCK),
        .rst_n (CLEAR),
        .en_i  (stall_en),
        .cnt_o (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLOCK),
        .rst_n (CLEAR),
        .en_i  (flush_en),
        .cnt_o (bus.flush_cnt)
    );

    assign bus.pc_write   = ctl.pc_write;
    assign bus.ifid_write = ctl.ifid_write;
    assign bus.ifid_flush = ctl.ifid_flush;
    assign bus.idex_flush = ctl.idex_flush;
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl
// (CNT_W=4 so counter saturation is reachable).
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.REG_AW(4), .CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(
        .REG_AW       (4),
        .DRAIN_CYCLES (3),
        .CNT_W        (4)
    ) dut (
        .CLOCK (clk),
        .CLEAR (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rs, rt, rd;
        logic        urs, urt, mr, wb, br, hd, rsm;
        logic [14:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt[16];

    function automatic logic [14:0] e(
        input logic pc, iw, ifl, ix, h,
        input logic [1:0] st,
        input logic [3:0] sc, fc
    );
        return {pc, iw, ifl, ix, h, st, sc, fc};
    endfunction

    function automatic vec_t v(
        input logic [3:0] rs, rt, rd,
        input logic urs, urt, mr, wb, br, hd, rsm,
        input logic [14:0] exp
    );
        vec_t r;
        r.rs = rs; r.rt = rt; r.rd = rd;
        r.urs = urs; r.urt = urt; r.mr = mr; r.wb = wb;
        r.br = br; r.hd = hd; r.rsm = rsm; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus.id_rs = x.rs;        bus.id_rt = x.rt;
        bus.ex_rd = x.rd;        bus.id_use_rs = x.urs;
        bus.id_use_rt = x.urt;   bus.ex_mem_read = x.mr;
        bus.ex_wb_en = x.wb;     bus.branch_taken = x.br;
        bus.halt_dec = x.hd;     bus.resume = x.rsm;
    endtask

    task automatic check(input string nm, input logic [14:0] exp);
        logic [14:0] act;
        act = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
               bus.idex_flush, bus.halted, bus.state,
               bus.stall_cnt, bus.flush_cnt};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc/iw/if/ix/h/st/sc/fc=%b_%b_%b_%b_%b_%b_%h_%h want %b_%b_%b_%b_%b_%b_%h_%h",
                     nm, act[14], act[13], act[12], act[11], act[10],
                     act[9:8], act[7:4], act[3:0],
                     exp[14], exp[13], exp[12], exp[11], exp[10],
                     exp[9:8], exp[7:4], exp[3:0]);
        end
    endtask

    vec_t idle;

    initial begin
        //            rs rt rd urs urt mr wb br hd rsm  pc iw if ix h st sc fc
        vt[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 0));
        vt[1]  = v(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
        vt[2]  = v(5, 0, 6, 1, 0, 1, 1, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 1, 0));
        vt[3]  = v(3, 3, 3, 0, 1, 1, 1, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 1, 0));
        vt[4]  = v(0, 0, 0, 1, 0, 1, 1, 1, 0, 0, e(0, 0, 0, 1, 0, 0, 2, 0));
        vt[5]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, e(1, 1, 1, 0, 0, 0, 3, 0));
        vt[6]  = v(5, 0, 5, 1, 0, 1, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 3, 1));
        vt[7]  = v(5, 0, 5, 0, 0, 1, 1, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 3, 1));
        vt[8]  = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, e(0, 1, 1, 0, 0, 0, 3, 1));
        vt[9]  = v(5, 0, 5, 1, 0, 1, 1, 1, 1, 1, e(0, 0, 1, 1, 0, 1, 3, 1));
        vt[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 0, 1, 1, 0, 1, 3, 1));
        vt[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 1, 3, 1));
        vt[12] = v(5, 0, 5, 1, 0, 1, 1, 1, 1, 0, e(0, 0, 0, 1, 1, 2, 3, 1));
        vt[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(0, 0, 0, 1, 1, 2, 3, 1));
        vt[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e(1, 1, 0, 0, 0, 0, 3, 1));
        vt[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 3, 1));
        idle = vt[0];

        // reset with random inputs: outputs must sit at RUN defaults
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            bus.id_rs = 4'($urandom);     bus.id_rt = 4'($urandom);
            bus.ex_rd = bus.id_rs;        bus.id_use_rs = 1'b1;
            bus.id_use_rt = 1'($urandom); bus.ex_mem_read = 1'b1;
            bus.ex_wb_en = 1'b1;          bus.branch_taken = 1'($urandom);
            bus.halt_dec = 1'($urandom);  bus.resume = 1'($urandom);
            @(negedge clk);
            check($sformatf("reset%0d", c), e(1, 1, 0, 0, 0, 0, 0, 0));
        end
        drive(idle);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive(vt[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        // 20 branch flushes on top of 1 must pin flush_cnt at 15
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 drive(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, '0));
        end
        @(posedge clk);
        #1 drive(idle);
        @(negedge clk);
        check("flush_sat", e(1, 1, 0, 0, 0, 0, 3, 15));

        // async reset in the middle of DRAIN
        @(posedge clk);
        #1 drive(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, '0));
        @(negedge clk);
        check("halt_enter", e(0, 1, 1, 0, 0, 0, 3, 15));
        @(posedge clk);
        #1 drive(v(5, 0, 5, 1, 0, 1, 1, 1, 0, 0, '0));
        @(negedge clk);
        check("drain_pre_rst", e(0, 0, 1, 1, 0, 1, 3, 15));
        #2 rst_n = 1'b0;
        #1 check("async_rst", e(1, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 drive(idle);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", e(1, 1, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards and stalls PC and IF/ID.
- Flushes IF/ID on taken branches resolved in ID.
- Drains the pipeline on HALT, then freezes it until resumed.
- Keeps saturating performance counters for stalls and flushes.
- Sits beside CONTROL: drives the PC write enable, the IF/ID write enable and the IF/ID and ID/EX flush inputs.

Parameters:
REG_AW, 4, register-specifier width (16 registers, no hardwired zero register)
DRAIN_CYCLES, 3, bubble cycles inserted after HALT leaves ID so that EX, MEM and WB retire
CNT_W, 16, performance counter width

Ports:
CLOCK  in  1  rising-edge clock
CLEAR  in  1  asynchronous active-low reset
id_rs  in  REG_AW  source register A of the instruction in ID (inst[11:8])
id_rt  in  REG_AW  source register B of the instruction in ID (inst[7:4])
id_use_rs  in  1  ID instruction reads id_rs
id_use_rt  in  1  ID instruction reads id_rt
ex_rd  in  REG_AW  destination register of the instruction in EX
ex_mem_read  in  1  EX instruction is a load (word or byte)
ex_wb_en  in  1  EX instruction writes the register file
branch_taken  in  1  branch compare/XOR result from ID
halt_dec  in  1  HALT decoded in ID
resume  in  1  leave HALTED (single pulse)
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero the IF/ID contents at the next edge
idex_flush  out  1  zero the ID/EX control fields at the next edge (bubble)
halted  out  1  pipeline frozen
state  out  2  FSM state: 00 RUN, 01 DRAIN, 10 HALTED
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Reset (CLEAR=0, asynchronous): state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0.
- Control outputs are a Mealy decode of state and the current inputs, so the outputs during reset are the RUN defaults: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- Hazard definition: hz = ex_mem_read & ex_wb_en & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)). Register 0 is compared like any other register.
- RUN, priority order (highest first):
  1. hz: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. branch_taken and halt_dec are ignored this cycle (their operands are not yet valid). stall_cnt+1. The stall lasts exactly 1 cycle, because the load advances to MEM.
  2. halt_dec: pc_write=0, ifid_flush=1, idex_flush=0 (HALT itself proceeds to EX). Load the drain counter with DRAIN_CYCLES-1, next state DRAIN. halt_dec wins over branch_taken.
  3. branch_taken: pc_write=1 (target loaded), ifid_flush=1, idex_flush=0. flush_cnt+1. Stay in RUN.
  4. Otherwise: defaults.
- DRAIN:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  - Drain counter decrements each cycle; when it is 0, next state is HALTED.
  - The state is DRAIN for exactly DRAIN_CYCLES cycles.
  - hz, branch_taken, halt_dec and resume are ignored.
- HALTED:
  - pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, halted=1 (the registered halted flag is high only in HALTED).
  - resume=1: next state RUN, with halted=0 from the following cycle. The PC resumes at HALT+2 (the PC already points past the killed fetch).
  - resume is ignored in RUN and DRAIN.
- Counters: increment by 1 on the qualifying edge and saturate at 2^CNT_W-1 (no wrap). They are cleared only by reset.
- Reset mid-DRAIN or mid-stall: immediate return to RUN defaults; counters cleared.

Decomposition:
- Shared package: state encodings (RUN, DRAIN, HALTED as 2-bit constants) and the REG_AW default, also used by CONTROL.
- One natural sub-module: sat_counter (CNT_W wide, enable, async active-low clear), instantiated twice for stall_cnt and flush_cnt.
- Hazard compare and FSM stay in this module.

Test Plan:
- Reset: CLEAR=0 for 2 cycles with random inputs -> state=00, pc_write=1, ifid_write=1, both flushes 0, halted=0, stall_cnt=flush_cnt=0.
- Load-use: ex_mem_read=1, ex_wb_en=1, ex_rd=5, id_rs=5, id_use_rs=1 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1. With ex_rd=6 -> no stall.
- Stall vs branch: hz=1 and branch_taken=1 together -> ifid_flush=0, flush_cnt unchanged. Next cycle, branch_taken=1 with hz=0 -> ifid_flush=1, pc_write=1, flush_cnt=1.
- Halt drain: halt_dec=1 in RUN -> state=01 for exactly 3 cycles with idex_flush=1, then state=10 and halted=1. resume during DRAIN is ignored.
- Resume: in HALTED, pulse resume -> next cycle state=00, pc_write=1, halted=0. A second resume while in RUN has no effect.
- Saturation and async reset: with CNT_W=4, 20 branch flushes -> flush_cnt=15. Assert CLEAR=0 mid-cycle while in DRAIN -> state=00 and counters=0 before the next clock edge.
